mm_bus_arbiter: RTL and testbench
=================================

Name: mm_bus_arbiter

Overview:
Shares the single status/control register bus (8-byte-aligned address, 64-bit data, ack-pulse completion) between two pulse-driven masters. Requester 0 is the PCIe TLP-to-register path; requester 1 is the local maintenance master. It latches each master's request, grants one transaction at a time using round-robin, and times out unacknowledged accesses. It returns ack, read data and timeout status to the granted master.

Parameters:
ADDR_W, 21, register bus address width (8-byte word address)
DATA_W, 64, register bus data width
TO_W, 20, timeout period/counter width

Ports:
iCLK  in  1  clock
iRST_N  in  1  asynchronous active-low reset
iTIMEOUT_PERIOD  in  TO_W  timeout in cycles from issue; 0 = timeout disabled
iREQ_WR_EN_PULSE  in  2  per-requester 1-cycle write request
iREQ_RD_EN_PULSE  in  2  per-requester 1-cycle read request
iREQ_ADDRESS  in  2*ADDR_W  per-requester address, packed; requester r at [r*ADDR_W +: ADDR_W]
iREQ_WR_DATA  in  2*DATA_W  per-requester write data, packed
oREQ_ACK_PULSE  out  2  per-requester completion pulse
oREQ_TIMEOUT  out  2  qualifies oREQ_ACK_PULSE: completion was a timeout
oREQ_OVERRUN_PULSE  out  2  request dropped
oREQ_RD_DATA  out  DATA_W  read data; valid with oREQ_ACK_PULSE
oMM_ADDRESS  out  ADDR_W  bus address
oMM_WR_DATA  out  DATA_W  bus write data
oMM_WR_EN_PULSE  out  1  bus write strobe
oMM_RD_EN_PULSE  out  1  bus read strobe
iMM_ACK_PULSE  in  1  bus completion (write done / read data valid)
iMM_RD_DATA  in  DATA_W  bus read data, valid with iMM_ACK_PULSE
oTIMEOUT_CTR_EN  out  1  1-cycle strobe per timeout; drives statistics counter
oSPURIOUS_ACK_PULSE  out  1  ack received with no transaction outstanding

Behaviour:
- Reset: all outputs 0; pending flags clear; FSM IDLE_ST; round-robin pointer favours requester 0; timeout counter 0.
- Capture: each requester has one pending slot (valid, is_write, addr, data). A request pulse on a free slot loads it at the clock edge; the slot is visible next cycle.
- Pulse on an occupied slot: dropped, oREQ_OVERRUN_PULSE[r] high next cycle, slot unchanged.
- Write and read pulse together from one requester: write loaded, read dropped, overrun flagged.
- Pulse in the same cycle the slot's ack is issued: the slot frees and reloads; no overrun.
- FSM states:
  - IDLE_ST: if any slot is pending, grant round-robin (the requester not last granted wins ties), latch bus fields, go to ISSUE_ST.
  - ISSUE_ST: registered oMM_WR_EN_PULSE or oMM_RD_EN_PULSE high for 1 cycle, oMM_ADDRESS/oMM_WR_DATA driven; go to WAIT_ACK_ST.
  - WAIT_ACK_ST: iMM_ACK_PULSE goes to RESP_ST with ok status. Timeout (counter == iTIMEOUT_PERIOD, period != 0) goes to RESP_ST with timeout status and oTIMEOUT_CTR_EN pulsed. If both occur in the same cycle, the ack wins.
  - RESP_ST: oREQ_ACK_PULSE[grant] high 1 cycle; oREQ_TIMEOUT[grant]=timeout status. oREQ_RD_DATA = captured iMM_RD_DATA for a read, all-ones on read timeout, 0 for a write. Clear the slot, update the pointer, go to IDLE_ST.
- An ack in ISSUE_ST is accepted as the completion.
- oMM_ADDRESS/oMM_WR_DATA hold their values from ISSUE_ST until the next grant.
- Timeout counter: cleared on entry to ISSUE_ST; increments each WAIT_ACK_ST cycle; saturates.
- Latency: request pulse at cycle 0 gives the bus strobe at cycle 2. Ack at cycle k gives oREQ_ACK_PULSE at k+1. The next strobe is at k+3 at the earliest.
- Ack in IDLE_ST or RESP_ST (including a late ack after timeout): ignored, oSPURIOUS_ACK_PULSE next cycle.
- Async reset mid-transaction: everything returns to reset state immediately; pending requests are lost, no ack issued.
- iTIMEOUT_PERIOD changed mid-wait: takes effect on the next comparison.

Decomposition:
- pcie_app_pkg gains: the FSM state enum (IDLE_ST, ISSUE_ST, WAIT_ACK_ST, RESP_ST), a mm_req_type struct (valid, is_write, addr, data), and a localparam MM_RD_TIMEOUT_DATA = all-ones.
- One sub-module, mm_req_slot: a single-requester pending slot with capture/overrun/clear logic, instantiated twice.

Test Plan:
- Req0 write addr 0x00010, data 0x1122334455667788 at cycle 0; ack at cycle 5 -> oMM_WR_EN_PULSE at cycle 2 with that addr/data; oREQ_ACK_PULSE[0] at cycle 6 with timeout 0.
- Req0 and req1 reads in the same cycle, each acked with 0xA/0xB -> requester 0 served first, then 1; each gets its own data; repeating alternates the starting order.
- iTIMEOUT_PERIOD=8, read with no ack -> oTIMEOUT_CTR_EN once; oREQ_ACK_PULSE with oREQ_TIMEOUT=1 and rd data all-ones; a later ack gives oSPURIOUS_ACK_PULSE.
- Second req1 pulse while its slot is pending -> oREQ_OVERRUN_PULSE[1]; only the first transaction reaches the bus.
- Ack and timeout in the same cycle -> ok completion, no oTIMEOUT_CTR_EN; iTIMEOUT_PERIOD=0 -> waits indefinitely.
- iRST_N low during WAIT_ACK_ST -> all outputs 0 immediately; after release, a new request is issued normally.

Source files
------------

// File: rtl/pcie_app_pkg.sv
// pcie_app_pkg: shared types for the register-bus arbiter (FSM states, pending request slot, timeout read data)
package pcie_app_pkg;
    localparam int MM_ADDR_W = 21;
    localparam int MM_DATA_W = 64;
    localparam logic [MM_DATA_W-1:0] MM_RD_TIMEOUT_DATA = '1;
    typedef enum logic [1:0] {IDLE_ST, ISSUE_ST, WAIT_ACK_ST, RESP_ST} mm_arb_state_e;
    typedef struct packed {
        logic                 valid;
        logic                 is_write;
        logic [MM_ADDR_W-1:0] addr;
        logic [MM_DATA_W-1:0] data;
    } mm_req_type;
endpackage

// File: rtl/mm_req_slot.sv
// mm_req_slot: one requester's pending-request slot
//   clk_i/rst_ni        clock, async active-low reset
//   wr_pulse_i/rd_pulse_i  1-cycle request strobes; addr_i/data_i request fields
//   clr_i               slot's completion is being returned this cycle
//   slot_o              registered slot contents; overrun_o dropped-request pulse
module mm_req_slot
    import pcie_app_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_pulse_i,
    input  logic                 rd_pulse_i,
    input  logic [MM_ADDR_W-1:0] addr_i,
    input  logic [MM_DATA_W-1:0] data_i,
    input  logic                 clr_i,
    output mm_req_type           slot_o,
    output logic                 overrun_o
);
    mm_req_type slot_d, slot_q;
    logic       overrun_d, overrun_q, free, req;

    // A slot being completed this cycle counts as free, so a back-to-back request reloads it.
    always_comb begin
        free      = !slot_q.valid || clr_i;
        req       = wr_pulse_i || rd_pulse_i;
        slot_d    = slot_q;
        if (clr_i) slot_d.valid = 1'b0;
        if (req && free) slot_d = '{valid: 1'b1, is_write: wr_pulse_i, addr: addr_i, data: data_i};
        // Simultaneous write+read keeps the write and drops the read.
        overrun_d = (wr_pulse_i && rd_pulse_i) || (req && !free);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            overrun_q <= overrun_d;
        end
    end

    assign slot_o    = slot_q;
    assign overrun_o = overrun_q;
endmodule

// File: rtl/mm_bus_arbiter.sv
// mm_bus_arbiter: round-robin sharing of the register bus between two pulse-driven masters, with ack timeout
//   iCLK/iRST_N                 clock, async active-low reset
//   iTIMEOUT_PERIOD             wait cycles before timeout (0 disables)
//   iREQ_*                      per-requester request strobes, address, write data (packed by requester)
//   oREQ_*                      per-requester completion pulse, timeout flag, overrun pulse; shared read data
//   oMM_* / iMM_*               register bus strobes, address, data and ack
//   oTIMEOUT_CTR_EN             one pulse per timeout; oSPURIOUS_ACK_PULSE ack with nothing outstanding
module mm_bus_arbiter
    import pcie_app_pkg::*;
#(
    parameter int ADDR_W = MM_ADDR_W,
    parameter int DATA_W = MM_DATA_W,
    parameter int TO_W   = 20
) (
    input  logic [0:0]        iCLK,
    input  logic              iRST_N,
    input  logic [TO_W-1:0]   iTIMEOUT_PERIOD,
    input  logic [1:0]        iREQ_WR_EN_PULSE,
    input  logic [1:0]        iREQ_RD_EN_PULSE,
    input  logic [2*ADDR_W-1:0] iREQ_ADDRESS,
    input  logic [2*DATA_W-1:0] iREQ_WR_DATA,
    output logic [1:0]        oREQ_ACK_PULSE,
    output logic [1:0]        oREQ_TIMEOUT,
    output logic [1:0]        oREQ_OVERRUN_PULSE,
    output logic [DATA_W-1:0] oREQ_RD_DATA,
    output logic [ADDR_W-1:0] oMM_ADDRESS,
    output logic [DATA_W-1:0] oMM_WR_DATA,
    output logic              oMM_WR_EN_PULSE,
    output logic              oMM_RD_EN_PULSE,
    input  logic              iMM_ACK_PULSE,
    input  logic [DATA_W-1:0] iMM_RD_DATA,
    output logic              oTIMEOUT_CTR_EN,
    output logic              oSPURIOUS_ACK_PULSE
);
    mm_arb_state_e     state_d, state_q;
    mm_req_type        slot [2];
    logic [1:0]        pend, clr;
    logic              grant_d, grant_q, last_d, last_q, is_wr_d, is_wr_q, to_d, to_q;
    logic              wr_en_d, wr_en_q, rd_en_d, rd_en_q, to_en_d, to_en_q, spur_d, spur_q;
    logic [TO_W-1:0]   ctr_d, ctr_q;
    logic [ADDR_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q, rdata_d, rdata_q;

    for (genvar r = 0; r < 2; r++) begin : g_slot
        mm_req_slot u_slot (
            .clk_i      (iCLK[0]),
            .rst_ni     (iRST_N),
            .wr_pulse_i (iREQ_WR_EN_PULSE[r]),
            .rd_pulse_i (iREQ_RD_EN_PULSE[r]),
            .addr_i     (iREQ_ADDRESS[r*ADDR_W +: ADDR_W]),
            .data_i     (iREQ_WR_DATA[r*DATA_W +: DATA_W]),
            .clr_i      (clr[r]),
            .slot_o     (slot[r]),
            .overrun_o  (oREQ_OVERRUN_PULSE[r])
        );
        assign pend[r] = slot[r].valid;
    end

    assign clr = (state_q == RESP_ST) ? (2'b01 << grant_q) : 2'b00;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        ctr_d   = ctr_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        to_d    = to_q;
        rdata_d = rdata_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        to_en_d = 1'b0;
        spur_d  = iMM_ACK_PULSE && (state_q == IDLE_ST || state_q == RESP_ST);
        unique case (state_q)
            IDLE_ST: if (|pend) begin
                // On a tie the requester not served last wins.
                grant_d = &pend ? ~last_q : pend[1];
                is_wr_d = slot[grant_d].is_write;
                addr_d  = slot[grant_d].addr;
                wdata_d = slot[grant_d].data;
                wr_en_d = is_wr_d;
                rd_en_d = !is_wr_d;
                ctr_d   = '0;
                state_d = ISSUE_ST;
            end
            ISSUE_ST, WAIT_ACK_ST: if (iMM_ACK_PULSE) begin
                to_d    = 1'b0;
                rdata_d = is_wr_q ? '0 : iMM_RD_DATA;
                state_d = RESP_ST;
            end else if (state_q == WAIT_ACK_ST && iTIMEOUT_PERIOD != '0 && ctr_q == iTIMEOUT_PERIOD) begin
                to_d    = 1'b1;
                to_en_d = 1'b1;
                rdata_d = is_wr_q ? '0 : MM_RD_TIMEOUT_DATA;
                state_d = RESP_ST;
            end else begin
                ctr_d   = (state_q == ISSUE_ST || &ctr_q) ? ctr_q : ctr_q + 1'b1;
                state_d = WAIT_ACK_ST;
            end
            RESP_ST: begin
                last_d  = grant_q;
                state_d = IDLE_ST;
            end
            default: state_d = IDLE_ST;
        endcase
    end

    always_ff @(posedge iCLK[0] or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE_ST;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            ctr_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            to_q    <= 1'b0;
            rdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            to_en_q <= 1'b0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            ctr_q   <= ctr_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            to_en_q <= to_en_d;
            spur_q  <= spur_d;
        end
    end

    assign oREQ_ACK_PULSE      = clr;
    assign oREQ_TIMEOUT        = to_q ? clr : 2'b00;
    assign oREQ_RD_DATA        = rdata_q;
    assign oMM_ADDRESS         = addr_q;
    assign oMM_WR_DATA         = wdata_q;
    assign oMM_WR_EN_PULSE     = wr_en_q;
    assign oMM_RD_EN_PULSE     = rd_en_q;
    assign oTIMEOUT_CTR_EN     = to_en_q;
    assign oSPURIOUS_ACK_PULSE = spur_q;
endmodule

// File: tb/tb_mm_bus_arbiter.sv
// tb_mm_bus_arbiter: directed and randomized checks of the arbiter against a request-level model
module tb_mm_bus_arbiter;
    logic [0:0]  iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic [19:0] period = 20'd30;
    logic [1:0]  wr_p = '0, rd_p = '0;
    logic [41:0] req_addr = '0;
    logic [127:0] req_wd = '0;
    logic        mm_ack = 1'b0;
    logic [63:0] mm_rd = '0;
    logic [1:0]  oREQ_ACK_PULSE, oREQ_TIMEOUT, oREQ_OVERRUN_PULSE;
    logic [63:0] oREQ_RD_DATA, oMM_WR_DATA;
    logic [20:0] oMM_ADDRESS;
    logic        oMM_WR_EN_PULSE, oMM_RD_EN_PULSE, oTIMEOUT_CTR_EN, oSPURIOUS_ACK_PULSE;

    int tests = 0, fails = 0;
    bit pend [2];
    bit pwr [2];
    logic [20:0] paddr [2];
    logic [63:0] pdata [2];
    int last = 1;

    mm_bus_arbiter dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iTIMEOUT_PERIOD(period),
        .iREQ_WR_EN_PULSE(wr_p), .iREQ_RD_EN_PULSE(rd_p),
        .iREQ_ADDRESS(req_addr), .iREQ_WR_DATA(req_wd),
        .oREQ_ACK_PULSE(oREQ_ACK_PULSE), .oREQ_TIMEOUT(oREQ_TIMEOUT),
        .oREQ_OVERRUN_PULSE(oREQ_OVERRUN_PULSE), .oREQ_RD_DATA(oREQ_RD_DATA),
        .oMM_ADDRESS(oMM_ADDRESS), .oMM_WR_DATA(oMM_WR_DATA),
        .oMM_WR_EN_PULSE(oMM_WR_EN_PULSE), .oMM_RD_EN_PULSE(oMM_RD_EN_PULSE),
        .iMM_ACK_PULSE(mm_ack), .iMM_RD_DATA(mm_rd),
        .oTIMEOUT_CTR_EN(oTIMEOUT_CTR_EN), .oSPURIOUS_ACK_PULSE(oSPURIOUS_ACK_PULSE)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] ra();
        return 21'($urandom);
    endfunction

    function automatic logic [63:0] rdt();
        return {$urandom, $urandom};
    endfunction

    function automatic logic any_out();
        return |{oREQ_ACK_PULSE, oREQ_TIMEOUT, oREQ_OVERRUN_PULSE, oREQ_RD_DATA, oMM_ADDRESS,
                 oMM_WR_DATA, oMM_WR_EN_PULSE, oMM_RD_EN_PULSE, oTIMEOUT_CTR_EN, oSPURIOUS_ACK_PULSE};
    endfunction

    // Drive one cycle of request pulses; the model predicts which are accepted and which overrun.
    task automatic pulse(input logic [1:0] wr, input logic [1:0] rd,
                         input logic [20:0] a0, input logic [20:0] a1,
                         input logic [63:0] d0, input logic [63:0] d1);
        logic [1:0] exp_ov;
        logic [20:0] a [2];
        logic [63:0] d [2];
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        exp_ov = '0;
        wr_p = wr; rd_p = rd; req_addr = {a1, a0}; req_wd = {d1, d0};
        for (int r = 0; r < 2; r++) begin
            if (wr[r] || rd[r]) begin
                if (pend[r]) exp_ov[r] = 1'b1;
                else begin
                    pend[r] = 1'b1; pwr[r] = wr[r]; paddr[r] = a[r]; pdata[r] = d[r];
                    exp_ov[r] = wr[r] && rd[r];
                end
            end
        end
        step();
        wr_p = '0; rd_p = '0;
        chk("overrun", {62'd0, oREQ_OVERRUN_PULSE}, {62'd0, exp_ov});
    endtask

    // Serve the transaction the model says is next. dly<0: never ack, expect a timeout.
    task automatic serve(input int dly, input int exp_wait);
        int r, w, n, nto, early;
        logic [63:0] rd, exp_rd;
        logic [1:0] m;
        r = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
        m = (r == 1) ? 2'b10 : 2'b01;
        w = 0; nto = 0; early = 0;
        while (!(oMM_WR_EN_PULSE || oMM_RD_EN_PULSE) && w < 30) begin
            step(); w++;
        end
        chk("strobe_seen", 64'(w < 30), 64'd1);
        if (exp_wait >= 0) chk("strobe_latency", 64'(w), 64'(exp_wait));
        chk("wr_strobe", {63'd0, oMM_WR_EN_PULSE}, {63'd0, pwr[r]});
        chk("rd_strobe", {63'd0, oMM_RD_EN_PULSE}, {63'd0, !pwr[r]});
        chk("bus_addr", {43'd0, oMM_ADDRESS}, {43'd0, paddr[r]});
        if (pwr[r]) chk("bus_wdata", oMM_WR_DATA, pdata[r]);
        rd = rdt();
        if (dly < 0) begin
            n = 0;
            while (oREQ_ACK_PULSE == 2'b00 && n < 100) begin
                step(); n++; nto += int'(oTIMEOUT_CTR_EN);
            end
            chk("timeout_latency", 64'(n), 64'(period) + 64'd2);
            exp_rd = pwr[r] ? 64'd0 : '1;
        end else begin
            for (int i = 0; i < dly; i++) begin
                step();
                nto += int'(oTIMEOUT_CTR_EN);
                early += int'(oREQ_ACK_PULSE != 2'b00);
            end
            mm_ack = 1'b1; mm_rd = rd;
            step();
            mm_ack = 1'b0;
            nto += int'(oTIMEOUT_CTR_EN);
            chk("early_ack", 64'(early), 64'd0);
            chk("no_spurious", {63'd0, oSPURIOUS_ACK_PULSE}, 64'd0);
            exp_rd = pwr[r] ? 64'd0 : rd;
        end
        chk("ack_pulse", {62'd0, oREQ_ACK_PULSE}, {62'd0, m});
        chk("ack_timeout", {62'd0, oREQ_TIMEOUT}, (dly < 0) ? {62'd0, m} : 64'd0);
        chk("rd_data", oREQ_RD_DATA, exp_rd);
        chk("timeout_strobes", 64'(nto), (dly < 0) ? 64'd1 : 64'd0);
        pend[r] = 1'b0;
        last = r;
    endtask

    initial begin
        int n;
        logic [1:0] m, w, x;
        pend[0] = 0; pend[1] = 0;
        repeat (3) step();
        chk("reset_outputs", {63'd0, any_out()}, 64'd0);
        iRST_N = 1'b1;
        step();
        // Directed write with known address/data; ack three cycles after the strobe.
        pulse(2'b01, 2'b00, 21'h00010, ra(), 64'h1122334455667788, rdt());
        serve(3, 1);
        // Simultaneous reads, then a tie after requester 0 went last.
        pulse(2'b00, 2'b11, ra(), ra(), rdt(), rdt());
        serve(2, 1);
        serve(1, 2);
        pulse(2'b00, 2'b01, ra(), ra(), rdt(), rdt());
        serve(0, 1);
        pulse(2'b00, 2'b11, ra(), ra(), rdt(), rdt());
        serve(1, 1);
        serve(1, 2);
        // Write and read together from one requester.
        pulse(2'b01, 2'b01, ra(), ra(), rdt(), rdt());
        serve(2, 1);
        // Second pulse into an occupied slot.
        pulse(2'b00, 2'b10, ra(), ra(), rdt(), rdt());
        pulse(2'b00, 2'b10, ra(), ra(), rdt(), rdt());
        serve(2, 0);
        n = 0;
        repeat (6) begin
            step();
            n += int'(oMM_WR_EN_PULSE || oMM_RD_EN_PULSE);
        end
        chk("dropped_not_issued", 64'(n), 64'd0);
        // Request in the same cycle its slot completes reloads without overrun.
        pulse(2'b01, 2'b00, ra(), ra(), rdt(), rdt());
        serve(1, 1);
        pulse(2'b00, 2'b01, ra(), ra(), rdt(), rdt());
        serve(2, 1);
        // Read timeout, then a late ack.
        period = 20'd8;
        pulse(2'b00, 2'b01, ra(), ra(), rdt(), rdt());
        serve(-1, 1);
        step(); step();
        mm_ack = 1'b1;
        step();
        mm_ack = 1'b0;
        chk("late_ack_spurious", {63'd0, oSPURIOUS_ACK_PULSE}, 64'd1);
        chk("late_ack_no_resp", {62'd0, oREQ_ACK_PULSE}, 64'd0);
        // Ack in the same cycle as the timeout comparison wins.
        period = 20'd4;
        pulse(2'b00, 2'b10, ra(), ra(), rdt(), rdt());
        serve(5, 1);
        // Timeout disabled: long wait still completes normally.
        period = 20'd0;
        pulse(2'b10, 2'b00, ra(), ra(), rdt(), rdt());
        serve(60, 1);
        // Randomized traffic.
        period = 20'd30;
        repeat (25) begin
            m = 2'($urandom_range(1, 3));
            w = 2'($urandom);
            x = 2'($urandom);
            pulse(m & w, m & (~w | x), ra(), ra(), rdt(), rdt());
            while (pend[0] || pend[1]) serve($urandom_range(0, 6), -1);
        end
        // Asynchronous reset while waiting for an ack, with another request pending.
        pulse(2'b00, 2'b01, ra(), ra(), rdt(), rdt());
        pulse(2'b10, 2'b00, ra(), ra(), rdt(), rdt());
        step(); step();
        #2 iRST_N = 1'b0;
        #1 chk("async_reset_outputs", {63'd0, any_out()}, 64'd0);
        step();
        iRST_N = 1'b1;
        pend[0] = 0; pend[1] = 0; last = 1;
        n = 0;
        repeat (5) begin
            step();
            n += int'(oMM_WR_EN_PULSE || oMM_RD_EN_PULSE || oREQ_ACK_PULSE != 2'b00);
        end
        chk("lost_after_reset", 64'(n), 64'd0);
        pulse(2'b10, 2'b00, ra(), ra(), rdt(), rdt());
        serve(2, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
